// File: rtl/pc_pkg.sv
// Shared op encodings for the ByteBlast program counter, its decoder and bench.
package pc_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'd0;
  localparam op_t OP_INC  = 3'd1;
  localparam op_t OP_JMP  = 3'd2;
  localparam op_t OP_BRA  = 3'd3;
  localparam op_t OP_CALL = 3'd4;
  localparam op_t OP_RET  = 3'd5;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Silently ignores push when full and pop when empty;
// fault reporting lives in the parent.
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    cnt;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DW'(DEPTH));
  assign depth   = cnt;
  assign wr_idx  = AW'(cnt);
  assign top_idx = AW'(cnt - DW'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end
  end

  // Storage is deliberately not reset; entries are invisible while empty.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// ByteBlast program counter: PC register, next-address mux, return stack
// and sticky overflow/underflow flags.
module pc_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_ADR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           target,
  input  logic [WIDTH-1:0]           offset,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           crnt_adr,
  output logic [WIDTH-1:0]           ret_adr,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stk_empty,
  output logic                       stk_full,
  output logic                       overflow,
  output logic                       underflow
);

  logic [WIDTH-1:0] adr_nxt;
  logic [WIDTH-1:0] adr_inc;
  logic             push;
  logic             pop;
  logic             ovf_evt;
  logic             udf_evt;

  assign adr_inc = crnt_adr + WIDTH'(1);

  always_comb begin
    adr_nxt = crnt_adr;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (enable) begin
      case (op)
        OP_INC:  adr_nxt = adr_inc;
        OP_JMP:  adr_nxt = target;
        OP_BRA:  adr_nxt = crnt_adr + offset;
        OP_CALL: begin
          if (stk_full) begin
            ovf_evt = 1'b1;
          end else begin
            push    = 1'b1;
            adr_nxt = target;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            udf_evt = 1'b1;
          end else begin
            pop     = 1'b1;
            adr_nxt = ret_adr;
          end
        end
        default: adr_nxt = crnt_adr;
      endcase
    end
  end

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (adr_inc),
    .top   (ret_adr),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // clear_err works regardless of enable; a same-cycle fault still sets.
  always_ff @(posedge clk) begin
    if (reset) begin
      crnt_adr  <= RESET_ADR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      crnt_adr  <= adr_nxt;
      overflow  <= (overflow  & ~clear_err) | ovf_evt;
      underflow <= (underflow & ~clear_err) | udf_evt;
    end
  end

endmodule
